// File: rtl/diffio_pattern_generator_sm.sv
// Drives a fixed-length LFSR bit stream (2 enabled cycles per bit) toward the DUT differential driver.
// Optional single-bit error injection is compiled in with `define DIFFIO_ERR_INJECT_EN.
module diffio_pattern_generator_sm #(
    parameter int unsigned NUM_BITS_TO_SEND = 1000,
    parameter logic [31:0] SEED             = 32'hABCDEF01,
    parameter int unsigned LEAD_CYCLES      = 0,
    parameter logic        IDLE_LEVEL       = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLK_EN,
    input  logic        START,
`ifdef DIFFIO_ERR_INJECT_EN
    input  logic        INJ_EN,
    input  logic [31:0] INJ_INDEX,
`endif
    output logic        BUSY,
    output logic        DONE,
    output logic        BIT_OUT,
    output logic        OE,
    output logic [31:0] BITS_SENT
);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_DRIVE, S_HOLD} state_t;

    localparam logic [31:0] LAST_IDX  = 32'(NUM_BITS_TO_SEND - 1);
    localparam logic [7:0]  LEAD_LAST = 8'(LEAD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [7:0]  lead_cnt_q, lead_cnt_d;
    logic [31:0] bits_sent_q, bits_sent_d;
    logic        bit_out_q, bit_out_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;

    // Inversion masks for the bit about to be loaded onto BIT_OUT.
    logic inj_start, inj_lead, inj_next;

`ifdef DIFFIO_ERR_INJECT_EN
    logic        inj_en_q, inj_en_d;
    logic [31:0] inj_idx_q, inj_idx_d;

    assign inj_start = INJ_EN && (INJ_INDEX == 32'd0);
    assign inj_lead  = inj_en_q && (inj_idx_q == 32'd0);
    assign inj_next  = inj_en_q && (inj_idx_q == 32'(bits_sent_q + 32'd1));

    always_comb begin
        inj_en_d  = inj_en_q;
        inj_idx_d = inj_idx_q;
        if (state_q == S_IDLE && START) begin
            inj_en_d  = INJ_EN;
            inj_idx_d = INJ_INDEX;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inj_en_q  <= 1'b0;
            inj_idx_q <= '0;
        end else if (CLK_EN) begin
            inj_en_q  <= inj_en_d;
            inj_idx_q <= inj_idx_d;
        end
    end
`else
    assign inj_start = 1'b0;
    assign inj_lead  = 1'b0;
    assign inj_next  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        lead_cnt_d  = lead_cnt_q;
        bits_sent_d = bits_sent_q;
        bit_out_d   = bit_out_q;
        oe_d        = oe_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    bits_sent_d = '0;
                    oe_d        = 1'b1;
                    lead_cnt_d  = '0;
                    if (LEAD_CYCLES > 0) begin
                        state_d   = S_LEAD;
                        bit_out_d = IDLE_LEVEL;
                    end else begin
                        state_d   = S_DRIVE;
                        bit_out_d = lfsr_q[31] ^ inj_start;
                    end
                end
            end
            S_LEAD: begin
                bit_out_d = IDLE_LEVEL;
                if (lead_cnt_q == LEAD_LAST) begin
                    state_d    = S_DRIVE;
                    lead_cnt_d = '0;
                    bit_out_d  = lfsr_q[31] ^ inj_lead;
                end else begin
                    lead_cnt_d = lead_cnt_q + 8'd1;
                end
            end
            S_DRIVE: state_d = S_HOLD;
            S_HOLD: begin
                bits_sent_d = bits_sent_q + 32'd1;
                if (bits_sent_q == LAST_IDX) begin
                    state_d   = S_IDLE;
                    lfsr_d    = SEED;
                    bit_out_d = IDLE_LEVEL;
                    oe_d      = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    // Next bit is the MSB after the shift, i.e. the current bit 30.
                    state_d   = S_DRIVE;
                    lfsr_d    = {lfsr_q[30:0], lfsr_q[30] ^ lfsr_q[27]};
                    bit_out_d = lfsr_q[30] ^ inj_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            lead_cnt_q  <= '0;
            bits_sent_q <= '0;
            bit_out_q   <= IDLE_LEVEL;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
        end else if (CLK_EN) begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            lead_cnt_q  <= lead_cnt_d;
            bits_sent_q <= bits_sent_d;
            bit_out_q   <= bit_out_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign BIT_OUT   = bit_out_q;
    assign OE        = oe_q;
    assign BITS_SENT = bits_sent_q;

endmodule

// File: tb/tb_diffio_pattern_generator_sm.sv
// Two generator instances (default params; N=20/LEAD=3/IDLE=1) checked every cycle against a
// run-timeline model: outputs follow from enabled cycles elapsed since START was accepted.
module tb_diffio_pattern_generator_sm;
    logic clk = 1'b0;
    logic rst, en, start;
    logic inj_en;
    logic [31:0] inj_index;
    logic [1:0] busy, done, bit_out, oe;
    logic [31:0] bits_sent [2];

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    diffio_pattern_generator_sm dut0 (
        .CLK(clk), .RST(rst), .CLK_EN(en), .START(start),
`ifdef DIFFIO_ERR_INJECT_EN
        .INJ_EN(inj_en), .INJ_INDEX(inj_index),
`endif
        .BUSY(busy[0]), .DONE(done[0]), .BIT_OUT(bit_out[0]), .OE(oe[0]), .BITS_SENT(bits_sent[0]));

    diffio_pattern_generator_sm #(.NUM_BITS_TO_SEND(20), .LEAD_CYCLES(3), .IDLE_LEVEL(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .CLK_EN(en), .START(start),
`ifdef DIFFIO_ERR_INJECT_EN
        .INJ_EN(inj_en), .INJ_INDEX(inj_index),
`endif
        .BUSY(busy[1]), .DONE(done[1]), .BIT_OUT(bit_out[1]), .OE(oe[1]), .BITS_SENT(bits_sent[1]));

    // ---------------- model ----------------
    bit pat [1000];
    bit m_act [2] = '{1'b0, 1'b0};
    int m_t [2] = '{0, 0};
    bit m_inj_en [2] = '{1'b0, 1'b0};
    int m_inj_idx [2] = '{0, 0};

    function automatic int pl(int i);   return (i == 0) ? 0 : 3;       endfunction
    function automatic int pn(int i);   return (i == 0) ? 1000 : 20;   endfunction
    function automatic bit pidle(int i); return (i == 0) ? 1'b0 : 1'b1; endfunction

    function automatic bit m_busy(int i);
        return m_act[i] && m_t[i] >= 1 && m_t[i] <= pl(i) + 2 * pn(i);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
                m_t[i]   <= 0;
            end else if (en) begin
                if (m_busy(i)) m_t[i] <= m_t[i] + 1;
                else if (start) begin
                    m_act[i] <= 1'b1;
                    m_t[i]   <= 1;
`ifdef DIFFIO_ERR_INJECT_EN
                    m_inj_en[i]  <= inj_en;
                    m_inj_idx[i] <= int'(inj_index);
`else
                    m_inj_en[i]  <= 1'b0;
                    m_inj_idx[i] <= 0;
`endif
                end else if (m_act[i]) m_t[i] <= pl(i) + 2 * pn(i) + 2;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int t = m_t[i];
            automatic int k = (t > pl(i)) ? (t - pl(i) - 1) / 2 : 0;
            automatic bit e_busy = m_busy(i);
            automatic bit e_done = m_act[i] && (t == pl(i) + 2 * pn(i) + 1);
            automatic bit e_bit = pidle(i);
            automatic int e_bits = 0;
            if (e_busy && t > pl(i)) e_bit = pat[k] ^ (m_inj_en[i] && m_inj_idx[i] == k);
            if (m_act[i] && t > pl(i)) e_bits = (k > pn(i)) ? pn(i) : k;
            vectors++;
            if ({busy[i], done[i], bit_out[i], oe[i]} !== {e_busy, e_done, e_bit, e_busy} ||
                bits_sent[i] !== 32'(e_bits)) begin
                miscompares++;
                $display("FAIL cycle dut%0d t=%0d: busy/done/bit/oe/bits_sent got %b%b%b%b/%0d want %b%b%b%b/%0d",
                         i, t, busy[i], done[i], bit_out[i], oe[i], bits_sent[i],
                         e_busy, e_done, e_bit, e_busy, e_bits);
            end
        end
    end

    task automatic chk(string nm, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [7:0]  p8;
        logic [15:0] v0;
        logic [6:0]  v1;
        bit          o1;
        int          done_cyc, ndone;

        d = 32'hABCDEF01;
        for (int k = 0; k < 1000; k++) begin
            pat[k] = d[31];
            d = {d[30:0], d[30] ^ d[27]};
        end
        for (int k = 0; k < 8; k++) p8[7-k] = pat[k];
        chk("model_seed_msbs", int'(p8), 8'hAB);

        rst = 1'b1; en = 1'b1; start = 1'b0; inj_en = 1'b0; inj_index = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_bits_sent", int'(bits_sent[0]), 0);
        chk("reset_busy_oe", int'({busy, oe}), 0);

        // Directed run: START accepted at cycle 0, sample cycles 1.. until DONE.
        start = 1'b1;
        step();
        start = 1'b0;
        o1 = 1'b1;
        done_cyc = -1;
        for (int c = 1; c <= 2100; c++) begin
            @(negedge clk);
            if (c <= 16) v0[16-c] = bit_out[0];
            if (c <= 7) v1[7-c] = bit_out[1];
            if (c <= 3) o1 = o1 & oe[1];
            if (done[0]) begin
                done_cyc = c;
                break;
            end
            step();
            if (c == 99) start = 1'b1;
            if (c == 100) start = 1'b0;
        end
        chk("first16_bits", int'(v0), 16'hCCCF);
        chk("lead_bits_dut1", int'(v1), 7'b1111100);
        chk("lead_oe_dut1", int'(o1), 1);
        chk("done_cycle", done_cyc, 2001);
        chk("final_bits_sent", int'(bits_sent[0]), 1000);
        step();
        chk("done_clears", int'(done[0]), 0);
        chk("bits_sent_holds", int'(bits_sent[0]), 1000);

        // Random enable/start/reset (and injection when built in).
        for (int c = 0; c < 8000; c++) begin
            en    = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 1499) == 0);
            inj_en    = $urandom_range(0, 1) == 1;
            inj_index = 32'($urandom_range(0, 25));
            step();
        end

        // START held high: IDLE re-entry after DONE restarts immediately.
        rst = 1'b1; en = 1'b1; start = 1'b0; inj_en = 1'b0;
        step();
        rst = 1'b0;
        start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 4010; c++) begin
            @(negedge clk);
            if (done[0]) ndone++;
            step();
        end
        start = 1'b0;
        chk("held_start_done_count", ndone, 2);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
